// File: rtl/reg_file_pkg.sv
// Shared sizing constants and helpers for the register file and its storage cells.
package reg_file_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 8;

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/reg_file_cell.sv
// Single storage register with clock enable; the whole file is built from these.
module reg_file_cell #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out <= '0;
      end else if (ce) begin
         out <= in;
      end
   end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with optional zero register, write bypass
// and a per-register pending (result in flight) scoreboard.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   localparam int AW      = addr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    ra_addr,
   input  logic [AW-1:0]    rb_addr,
   output logic [WIDTH-1:0] ra_data,
   output logic [WIDTH-1:0] rb_data,
   input  logic             issue,
   input  logic [AW-1:0]    issue_addr,
   output logic             busy_a,
   output logic             busy_b,
   output logic [AW:0]      pend_cnt
);

   logic [WIDTH-1:0] q [DEPTH];
   logic [DEPTH-1:0] ce;
   logic             cell_reset;
   logic             fwd_en;
   logic             ra_hit;
   logic             rb_hit;
   logic             issue_ok;
   logic [DEPTH-1:0] pending;
   logic [DEPTH-1:0] pending_next;
   logic [AW:0]      cnt_next;

   assign cell_reset = ~rst_n;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_reg
         assign ce[i] = we && (waddr == AW'(i)) && !(ZERO_REG && (i == 0));

         reg_file_cell #(
            .WIDTH (WIDTH)
         ) u_cell (
            .clk   (clk),
            .reset (cell_reset),
            .ce    (ce[i]),
            .in    (wdata),
            .out   (q[i])
         );
      end
   endgenerate

   // Forwarding is suppressed while reset is held so outputs show the cleared state.
   assign fwd_en = BYPASS && we && rst_n;
   assign ra_hit = fwd_en && (waddr == ra_addr);
   assign rb_hit = fwd_en && (waddr == rb_addr);

   assign ra_data = (ZERO_REG && (ra_addr == '0)) ? '0 : (ra_hit ? wdata : q[ra_addr]);
   assign rb_data = (ZERO_REG && (rb_addr == '0)) ? '0 : (rb_hit ? wdata : q[rb_addr]);

   assign busy_a = pending[ra_addr] && !ra_hit;
   assign busy_b = pending[rb_addr] && !rb_hit;

   assign issue_ok = issue && !(ZERO_REG && (issue_addr == '0));

   // Clear on write first so a same-cycle issue to that register wins.
   always_comb begin
      pending_next = pending;
      if (we) begin
         pending_next[waddr] = 1'b0;
      end
      if (issue_ok) begin
         pending_next[issue_addr] = 1'b1;
      end
      cnt_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt_next = cnt_next + (AW+1)'(pending_next[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         pend_cnt <= '0;
      end else begin
         pending  <= pending_next;
         pend_cnt <= cnt_next;
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: table-driven vectors through a scoreboard queue,
// plus hand-written reset and full-scoreboard sequences.
module tb_reg_file;
   import reg_file_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int NVEC  = 21;

   typedef struct {
      logic             we;
      logic [AW-1:0]    waddr;
      logic [WIDTH-1:0] wdata;
      logic [AW-1:0]    ra;
      logic [AW-1:0]    rb;
      logic             issue;
      logic [AW-1:0]    iaddr;
      logic [WIDTH-1:0] exp_ra;
      logic [WIDTH-1:0] exp_rb;
      logic             exp_ba;
      logic             exp_bb;
      logic [AW:0]      exp_cnt;
      logic [WIDTH-1:0] exp_ra_nb;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic [AW-1:0]    ra_addr;
   logic [AW-1:0]    rb_addr;
   logic             issue;
   logic [AW-1:0]    issue_addr;
   logic [WIDTH-1:0] ra_data, rb_data;
   logic             busy_a, busy_b;
   logic [AW:0]      pend_cnt;
   logic [WIDTH-1:0] ra_data_nb, rb_data_nb;
   logic             busy_a_nb, busy_b_nb;
   logic [AW:0]      pend_cnt_nb;

   vec_t vecs [NVEC];
   vec_t sb [$];
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
      .issue(issue), .issue_addr(issue_addr), .busy_a(busy_a), .busy_b(busy_b),
      .pend_cnt(pend_cnt)
   );

   reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data_nb), .rb_data(rb_data_nb),
      .issue(issue), .issue_addr(issue_addr), .busy_a(busy_a_nb), .busy_b(busy_b_nb),
      .pend_cnt(pend_cnt_nb)
   );

   function automatic vec_t mk(input logic w, input int wa, input int wd, input int a, input int b,
                               input logic is, input int ia, input int era, input int erb,
                               input logic eba, input logic ebb, input int ecnt, input int enb);
      vec_t v;
      v.we = w;            v.waddr = AW'(wa);        v.wdata = WIDTH'(wd);
      v.ra = AW'(a);       v.rb = AW'(b);
      v.issue = is;        v.iaddr = AW'(ia);
      v.exp_ra = WIDTH'(era); v.exp_rb = WIDTH'(erb);
      v.exp_ba = eba;      v.exp_bb = ebb;
      v.exp_cnt = (AW+1)'(ecnt); v.exp_ra_nb = WIDTH'(enb);
      return v;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic driveIdle();
      we = 1'b0; waddr = '0; wdata = '0; issue = 1'b0; issue_addr = '0;
   endtask

   task automatic applyStimulus(input vec_t v);
      @(posedge clk);
      #1;
      we = v.we; waddr = v.waddr; wdata = v.wdata;
      ra_addr = v.ra; rb_addr = v.rb;
      issue = v.issue; issue_addr = v.iaddr;
      sb.push_back(v);
   endtask

   task automatic checkOutput(input int idx);
      vec_t e;
      if (sb.size() == 0) begin
         checks++;
         $display("[TB] FAIL scoreboard_empty vec%0d: got 0 entries expected 1", idx);
      end else begin
         e = sb.pop_front();
         checkVal($sformatf("vec%0d ra_data", idx), 32'(ra_data), 32'(e.exp_ra));
         checkVal($sformatf("vec%0d rb_data", idx), 32'(rb_data), 32'(e.exp_rb));
         checkVal($sformatf("vec%0d busy_a", idx), 32'(busy_a), 32'(e.exp_ba));
         checkVal($sformatf("vec%0d busy_b", idx), 32'(busy_b), 32'(e.exp_bb));
         checkVal($sformatf("vec%0d pend_cnt", idx), 32'(pend_cnt), 32'(e.exp_cnt));
         checkVal($sformatf("vec%0d ra_data_nobypass", idx), 32'(ra_data_nb), 32'(e.exp_ra_nb));
      end
   endtask

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      //        we wa wd    ra rb is ia  era   erb   ba bb cnt nb
      vecs[0]  = mk(0, 0, 0,     0, 7, 0, 0, 0,    0,    0, 0, 0, 0);
      vecs[1]  = mk(0, 0, 0,     1, 6, 0, 0, 0,    0,    0, 0, 0, 0);
      vecs[2]  = mk(0, 0, 0,     2, 5, 0, 0, 0,    0,    0, 0, 0, 0);
      vecs[3]  = mk(0, 0, 0,     3, 4, 0, 0, 0,    0,    0, 0, 0, 0);
      vecs[4]  = mk(1, 3, 'hA5,  3, 4, 0, 0, 'hA5, 0,    0, 0, 0, 0);
      vecs[5]  = mk(0, 0, 0,     3, 3, 0, 0, 'hA5, 'hA5, 0, 0, 0, 'hA5);
      vecs[6]  = mk(1, 0, 'hFF,  0, 0, 0, 0, 0,    0,    0, 0, 0, 0);
      vecs[7]  = mk(0, 0, 0,     0, 3, 0, 0, 0,    'hA5, 0, 0, 0, 0);
      vecs[8]  = mk(0, 0, 0,     0, 0, 1, 0, 0,    0,    0, 0, 0, 0);
      vecs[9]  = mk(0, 0, 0,     5, 0, 1, 5, 0,    0,    0, 0, 0, 0);
      vecs[10] = mk(0, 0, 0,     5, 6, 1, 6, 0,    0,    1, 0, 1, 0);
      vecs[11] = mk(0, 0, 0,     5, 6, 0, 0, 0,    0,    1, 1, 2, 0);
      vecs[12] = mk(1, 5, 'h3C,  5, 6, 0, 0, 'h3C, 0,    0, 1, 2, 0);
      vecs[13] = mk(0, 0, 0,     5, 6, 0, 0, 'h3C, 0,    0, 1, 1, 'h3C);
      vecs[14] = mk(0, 0, 0,     2, 2, 1, 2, 0,    0,    0, 0, 1, 0);
      vecs[15] = mk(0, 0, 0,     2, 0, 1, 2, 0,    0,    1, 0, 2, 0);
      vecs[16] = mk(1, 2, 'h5A,  2, 2, 1, 2, 'h5A, 'h5A, 0, 0, 2, 0);
      vecs[17] = mk(0, 0, 0,     2, 6, 0, 0, 'h5A, 0,    1, 1, 2, 'h5A);
      vecs[18] = mk(1, 6, 'h77,  7, 1, 0, 0, 0,    0,    0, 0, 2, 0);
      vecs[19] = mk(1, 7, 'h11,  6, 7, 0, 0, 'h77, 'h11, 0, 0, 1, 'h77);
      vecs[20] = mk(0, 0, 0,     7, 2, 0, 0, 'h11, 'h5A, 0, 1, 1, 'h11);

      rst_n = 1'b0;
      driveIdle();
      ra_addr = 3'd3; rb_addr = 3'd5;
      #2;
      checkVal("reset ra_data", 32'(ra_data), 32'h0);
      checkVal("reset rb_data", 32'(rb_data), 32'h0);
      checkVal("reset busy_a", 32'(busy_a), 32'h0);
      checkVal("reset pend_cnt", 32'(pend_cnt), 32'h0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i]);
         #3;
         checkOutput(i);
      end

      // Fill the pending scoreboard (r2 is already pending from the table).
      for (int a = 1; a < DEPTH; a++) begin
         @(posedge clk);
         #1;
         driveIdle();
         issue = 1'b1; issue_addr = AW'(a);
      end
      @(posedge clk);
      #1;
      driveIdle();
      ra_addr = 3'd7; rb_addr = 3'd5;
      #2;
      checkVal("full pend_cnt", 32'(pend_cnt), 32'd7);
      checkVal("full busy_a", 32'(busy_a), 32'h1);
      checkVal("full busy_b", 32'(busy_b), 32'h1);
      checkVal("full ra_data", 32'(ra_data), 32'h11);
      checkVal("full rb_data", 32'(rb_data), 32'h3C);
      #1 rst_n = 1'b0;
      #1;
      checkVal("pulse ra_data", 32'(ra_data), 32'h0);
      checkVal("pulse rb_data", 32'(rb_data), 32'h0);
      checkVal("pulse busy_a", 32'(busy_a), 32'h0);
      checkVal("pulse busy_b", 32'(busy_b), 32'h0);
      checkVal("pulse pend_cnt", 32'(pend_cnt), 32'h0);
      checkVal("pulse ra_data_nobypass", 32'(ra_data_nb), 32'h0);
      #1 rst_n = 1'b1;
      #2;
      checkVal("after pulse rb_data", 32'(rb_data), 32'h0);
      checkVal("after pulse pend_cnt", 32'(pend_cnt), 32'h0);

      // Write and issue in flight when reset hits: both must be discarded.
      @(posedge clk);
      #1;
      we = 1'b1; waddr = 3'd4; wdata = 8'h99;
      issue = 1'b1; issue_addr = 3'd4;
      ra_addr = 3'd4; rb_addr = 3'd4;
      #1 rst_n = 1'b0;
      #1;
      checkVal("inflight ra_data", 32'(ra_data), 32'h0);
      checkVal("inflight busy_b", 32'(busy_b), 32'h0);
      @(posedge clk);
      #1;
      driveIdle();
      #1 rst_n = 1'b1;
      #1;
      checkVal("discard rb_data", 32'(rb_data), 32'h0);
      checkVal("discard busy_a", 32'(busy_a), 32'h0);
      checkVal("discard pend_cnt", 32'(pend_cnt), 32'h0);
      we = 1'b1; waddr = 3'd1; wdata = 8'h42;
      issue = 1'b1; issue_addr = 3'd3;
      ra_addr = 3'd1; rb_addr = 3'd3;
      @(posedge clk);
      #1;
      driveIdle();
      #2;
      checkVal("first edge ra_data", 32'(ra_data), 32'h42);
      checkVal("first edge ra_data_nobypass", 32'(ra_data_nb), 32'h42);
      checkVal("first edge busy_b", 32'(busy_b), 32'h1);
      checkVal("first edge pend_cnt", 32'(pend_cnt), 32'd1);

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
